// File: rtl/cbx_param_cfg_if.sv
// Bundle of the connection-block signals: channel feedthroughs, grid input
// pins and the serial configuration chain.
//   master : the side that drives channel inputs and the config chain
//   slave  : the connection block itself
// Parameters:
//   CHAN_W   - tracks per direction
//   NUM_IPIN - grid input pins driven
interface cbx_param_cfg_if #(
    parameter int CHAN_W   = 3,
    parameter int NUM_IPIN = 2
);
    logic [CHAN_W-1:0]   chanx_left_in;
    logic [CHAN_W-1:0]   chanx_right_in;
    logic [CHAN_W-1:0]   chanx_left_out;
    logic [CHAN_W-1:0]   chanx_right_out;
    logic [NUM_IPIN-1:0] ipin_out;
    logic                ccff_head;
    logic                ccff_en;
    logic                ccff_commit;
    logic                ccff_tail;
    logic                cfg_done;
    logic                cfg_err;

    modport master (
        output chanx_left_in, chanx_right_in, ccff_head, ccff_en, ccff_commit,
        input  chanx_left_out, chanx_right_out, ipin_out, ccff_tail, cfg_done, cfg_err
    );

    modport slave (
        input  chanx_left_in, chanx_right_in, ccff_head, ccff_en, ccff_commit,
        output chanx_left_out, chanx_right_out, ipin_out, ccff_tail, cfg_done, cfg_err
    );
endinterface

// File: rtl/cbx_param_cfg.sv
// X-channel connection block with a shadowed, counted configuration chain.
// Channel tracks pass straight through in both directions. Each grid input
// pin selects one track (or constant 0) through its own mux, optionally
// registered. Config bits shift into a shadow register and only reach the
// live pin selects on an accepted commit.
// Ports:
//   prog_clk      - clock for config chain and pin registers
//   prog_reset_n  - synchronous active-low reset
//   bus (slave)   - channel in/out, ipin_out, ccff_head/en/commit,
//                   ccff_tail, cfg_done, cfg_err
module cbx_param_cfg #(
    parameter  int CHAN_W   = 3,
    parameter  int NUM_IPIN = 2,
    localparam int SEL_W    = $clog2(2*CHAN_W+1),
    localparam int CFG_BITS = NUM_IPIN*(SEL_W+1),
    localparam int CNT_W    = $clog2(CFG_BITS+1)
) (
    input  logic             prog_clk,
    input  logic             prog_reset_n,
    cbx_param_cfg_if.slave   bus
);

    logic [CFG_BITS-1:0] shift_q;
    logic [CFG_BITS-1:0] active_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                done_q;
    logic                err_q;
    logic [NUM_IPIN-1:0] pin_q;
    logic [NUM_IPIN-1:0] mux;
    logic [NUM_IPIN-1:0] reg_mode;
    logic [SEL_W-1:0]    sel;
    logic                commit_ok;

    assign bus.chanx_left_out  = bus.chanx_right_in;
    assign bus.chanx_right_out = bus.chanx_left_in;

    assign commit_ok = bus.ccff_commit & done_q;

    // A commit restarts the count; a shift in the same cycle counts as the
    // first bit of the next load.
    always_comb begin
        cnt_nxt = cnt_q;
        if (commit_ok) begin
            cnt_nxt = bus.ccff_en ? CNT_W'(1) : '0;
        end else if (bus.ccff_en && (cnt_q != CNT_W'(CFG_BITS))) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            shift_q  <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            pin_q    <= '0;
        end else begin
            if (bus.ccff_en) begin
                shift_q <= {shift_q[CFG_BITS-2:0], bus.ccff_head};
            end
            // shift_q here is the pre-shift value, so commit+shift copies the
            // fully loaded word.
            if (commit_ok) begin
                active_q <= shift_q;
            end
            cnt_q  <= cnt_nxt;
            done_q <= (cnt_nxt == CNT_W'(CFG_BITS));
            err_q  <= bus.ccff_commit & ~done_q;
            pin_q  <= mux;
        end
    end

    // Per-pin decode: 0 = off, 1..CHAN_W = left track, CHAN_W+1..2*CHAN_W =
    // right track, anything above is treated as off.
    always_comb begin
        mux      = '0;
        reg_mode = '0;
        sel      = '0;
        for (int i = 0; i < NUM_IPIN; i++) begin
            sel         = active_q[i*(SEL_W+1) +: SEL_W];
            reg_mode[i] = active_q[i*(SEL_W+1) + SEL_W];
            for (int k = 0; k < CHAN_W; k++) begin
                if (sel == SEL_W'(k + 1)) begin
                    mux[i] = bus.chanx_left_in[k];
                end
                if (sel == SEL_W'(CHAN_W + 1 + k)) begin
                    mux[i] = bus.chanx_right_in[k];
                end
            end
        end
    end

    assign bus.ipin_out  = (reg_mode & pin_q) | (~reg_mode & mux);
    assign bus.ccff_tail = shift_q[CFG_BITS-1];
    assign bus.cfg_done  = done_q;
    assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_cbx_param_cfg.sv
// Directed bench for cbx_param_cfg at default parameters
// (CHAN_W=3, NUM_IPIN=2, SEL_W=3, CFG_BITS=8).
// Config word layout: [3:0] = pin0 {reg, sel[2:0]}, [7:4] = pin1 {reg, sel}.
// Words shift in MSB first.
module tb_cbx_param_cfg;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    cbx_param_cfg_if #(.CHAN_W(3), .NUM_IPIN(2)) bus ();

    cbx_param_cfg #(.CHAN_W(3), .NUM_IPIN(2)) dut (
        .prog_clk     (clk),
        .prog_reset_n (rst_n),
        .bus          (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shift word bits hi down to lo, one per clock.
    task automatic shift_bits(input logic [7:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            bus.ccff_head = w[i];
            bus.ccff_en   = 1'b1;
            tick();
        end
        bus.ccff_en   = 1'b0;
        bus.ccff_head = 1'b0;
    endtask

    task automatic commit();
        bus.ccff_commit = 1'b1;
        tick();
        bus.ccff_commit = 1'b0;
    endtask

    logic [15:0] pat;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        pat      = 16'b1011_0010_1110_0101;

        rst_n              = 1'b0;
        bus.ccff_head      = 1'b0;
        bus.ccff_en        = 1'b0;
        bus.ccff_commit    = 1'b0;
        bus.chanx_left_in  = 3'b111;
        bus.chanx_right_in = 3'b111;

        // Reset state
        tick();
        tick();
        chk("rst_ipin", 8'(bus.ipin_out), 8'h00);
        chk("rst_done", 8'(bus.cfg_done), 8'h00);
        chk("rst_tail", 8'(bus.ccff_tail), 8'h00);
        chk("rst_err", 8'(bus.cfg_err), 8'h00);
        bus.chanx_right_in = 3'b101;
        bus.chanx_left_in  = 3'b011;
        #1;
        chk("feed_left_out", 8'(bus.chanx_left_out), 8'h05);
        chk("feed_right_out", 8'(bus.chanx_right_out), 8'h03);
        rst_n = 1'b1;
        tick();

        // Load pin0 = sel2 comb, pin1 = sel5 registered
        bus.chanx_left_in  = 3'b010;
        bus.chanx_right_in = 3'b010;
        shift_bits(8'b1101_0010, 7, 1);
        chk("load_done_7", 8'(bus.cfg_done), 8'h00);
        shift_bits(8'b1101_0010, 0, 0);
        chk("load_done_8", 8'(bus.cfg_done), 8'h01);
        chk("load_ipin_pre", 8'(bus.ipin_out), 8'h00);
        commit();
        chk("commit_ipin_c1", 8'(bus.ipin_out), 8'h01);
        chk("commit_done_clr", 8'(bus.cfg_done), 8'h00);
        tick();
        chk("commit_ipin_c2", 8'(bus.ipin_out), 8'h03);
        bus.chanx_right_in = 3'b000;
        #1;
        chk("lat_pin1_hold", 8'(bus.ipin_out), 8'h03);
        tick();
        chk("lat_pin1_drop", 8'(bus.ipin_out), 8'h01);
        bus.chanx_left_in = 3'b000;
        #1;
        chk("lat_pin0_comb", 8'(bus.ipin_out), 8'h00);
        bus.chanx_left_in  = 3'b010;
        bus.chanx_right_in = 3'b010;
        tick();
        chk("lat_restore", 8'(bus.ipin_out), 8'h03);

        // Early commit with 5 bits: pin0 sel7, pin1 sel0
        shift_bits(8'b0000_0111, 7, 3);
        chk("early_done", 8'(bus.cfg_done), 8'h00);
        commit();
        chk("early_err", 8'(bus.cfg_err), 8'h01);
        chk("early_ipin", 8'(bus.ipin_out), 8'h03);
        tick();
        chk("early_err_clr", 8'(bus.cfg_err), 8'h00);
        chk("early_ipin2", 8'(bus.ipin_out), 8'h03);
        shift_bits(8'b0000_0111, 2, 1);
        chk("early_done_7", 8'(bus.cfg_done), 8'h00);
        shift_bits(8'b0000_0111, 0, 0);
        chk("early_done_8", 8'(bus.cfg_done), 8'h01);

        // Out-of-range / off codes
        bus.chanx_left_in  = 3'b111;
        bus.chanx_right_in = 3'b111;
        commit();
        chk("oor_err", 8'(bus.cfg_err), 8'h00);
        chk("oor_ipin", 8'(bus.ipin_out), 8'h00);
        tick();
        chk("oor_ipin2", 8'(bus.ipin_out), 8'h00);

        // Commit and shift together: pin0 sel4 (right[0]), pin1 sel1 (left[0])
        shift_bits(8'b0001_0100, 7, 0);
        chk("cs_done_pre", 8'(bus.cfg_done), 8'h01);
        bus.ccff_en     = 1'b1;
        bus.ccff_head   = 1'b1;
        bus.ccff_commit = 1'b1;
        tick();
        bus.ccff_en     = 1'b0;
        bus.ccff_head   = 1'b0;
        bus.ccff_commit = 1'b0;
        chk("cs_done", 8'(bus.cfg_done), 8'h00);
        chk("cs_err", 8'(bus.cfg_err), 8'h00);
        bus.chanx_left_in  = 3'b001;
        bus.chanx_right_in = 3'b000;
        #1;
        chk("cs_ipin_left", 8'(bus.ipin_out), 8'h02);
        bus.chanx_left_in  = 3'b000;
        bus.chanx_right_in = 3'b001;
        #1;
        chk("cs_ipin_right", 8'(bus.ipin_out), 8'h01);
        shift_bits(8'h00, 5, 0);
        chk("cs_cnt_7", 8'(bus.cfg_done), 8'h00);
        shift_bits(8'h00, 0, 0);
        chk("cs_cnt_8", 8'(bus.cfg_done), 8'h01);

        // Chain passthrough from a clean chain
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            bus.ccff_head = pat[16-n];
            bus.ccff_en   = 1'b1;
            tick();
            bus.ccff_en = 1'b0;
            chk($sformatf("tail_%0d", n), 8'(bus.ccff_tail), (n >= 8) ? 8'(pat[23-n]) : 8'h00);
            if (n == 10) begin
                tick();
                tick();
                chk("tail_hold", 8'(bus.ccff_tail), 8'(pat[13]));
            end
        end
        chk("tail_sat_done", 8'(bus.cfg_done), 8'h01);

        // Reset overrides a simultaneous commit and clears the chain
        bus.chanx_left_in  = 3'b111;
        bus.chanx_right_in = 3'b111;
        rst_n           = 1'b0;
        bus.ccff_commit = 1'b1;
        tick();
        chk("mid_rst_tail", 8'(bus.ccff_tail), 8'h00);
        chk("mid_rst_done", 8'(bus.cfg_done), 8'h00);
        chk("mid_rst_ipin", 8'(bus.ipin_out), 8'h00);
        rst_n           = 1'b1;
        bus.ccff_commit = 1'b0;
        tick();
        chk("post_rst_err", 8'(bus.cfg_err), 8'h00);
        chk("post_rst_ipin", 8'(bus.ipin_out), 8'h00);
        shift_bits(8'h00, 6, 0);
        chk("post_rst_cnt_7", 8'(bus.cfg_done), 8'h00);
        shift_bits(8'h00, 0, 0);
        chk("post_rst_cnt_8", 8'(bus.cfg_done), 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
